mp_out: RTL
===========

MP_OUT -- requirements
Module: mp_out

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, core word width in bits.
REQ-002 SHALL have parameter BLOCK_BYTES, default 16, bytes per AES block.
REQ-003 SHALL have port clk, input, 1, rising-edge system clock.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port core_data_in, input, DATA_WIDTH, ciphertext word from core.
REQ-006 SHALL have port core_dv_in, input, 1, core_data_in valid this cycle.
REQ-007 SHALL have port tx_done_in, input, 1, one-cycle pulse from UART TX when a byte has finished.
REQ-008 SHALL have port tx_byte_out, output, 8, byte presented to UART TX.
REQ-009 SHALL have port tx_dv_out, output, 1, one-cycle start pulse to UART TX.
REQ-010 SHALL have port busy_out, output, 1, high in every state except IDLE.
REQ-011 SHALL have port done_out, output, 1, one-cycle pulse after the last byte of a block completes.
REQ-012 SHALL have port ovf_out, output, 1, one-cycle pulse when core_dv_in arrives while words cannot be accepted.

Function
REQ-013 SHALL implement states IDLE, COLLECT, SEND, WAIT_TX and DONE with a registered state and combinational next-state logic.
REQ-014 SHALL hold a 128-bit block register; word k (0..3, by arrival order) SHALL be stored at bits [127-32k -: 32].
REQ-015 IDLE: core_dv_in high SHALL store word 0, set word count to 1 and move to COLLECT.
REQ-016 COLLECT: each core_dv_in high SHALL store the next word and increment the word count; cycles with core_dv_in low SHALL hold everything (gaps allowed).
REQ-017 COLLECT: when the 4th word is stored, SHALL move to SEND on that edge and clear the byte count to 0.
REQ-018 SEND: SHALL assert tx_dv_out for exactly one cycle, then move unconditionally to WAIT_TX.
REQ-019 tx_byte_out SHALL equal block[127-8n -: 8] (n = byte count) in SEND and WAIT_TX, and SHALL be 8'h00 otherwise.
REQ-020 WAIT_TX: tx_done_in high with byte count < 15 SHALL increment the byte count and move to SEND.
REQ-021 WAIT_TX: tx_done_in high with byte count = 15 SHALL move to DONE.
REQ-022 WAIT_TX: tx_done_in low SHALL hold state and byte count indefinitely (no timeout).
REQ-023 DONE: SHALL assert done_out for one cycle and move to IDLE with both counters at 0.
REQ-024 tx_done_in outside WAIT_TX SHALL be ignored.
REQ-025 core_dv_in in SEND, WAIT_TX or DONE SHALL be dropped (block register unchanged) and SHALL pulse ovf_out in the same cycle (combinational).
REQ-026 Latency: the edge that stores word 3 puts the block in SEND, so tx_dv_out is high the following cycle; tx_done_in at edge k gives the next tx_dv_out in cycle k+1.
REQ-027 Per block: 16 tx_dv_out pulses, in byte order MSB first, each separated from the previous pulse by at least one tx_done_in.
REQ-028 Unreachable state encodings SHALL go to IDLE on the next edge.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, clear the counters and block register, and drive all outputs to 0.
REQ-030 Reset during SEND or WAIT_TX SHALL abandon the block; after release, no further tx_dv_out SHALL occur until four new words arrive.

Verification
REQ-031 Four back-to-back words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF, with TX modelled at 10-cycle tx_done_in -> bytes 0x00,0x11,...,0xFF in order, 16 tx_dv_out pulses, then done_out one cycle after the 16th tx_done_in, then busy_out = 0.
REQ-032 Same four words with 3 idle cycles between each core_dv_in -> identical byte stream, with the first tx_dv_out one cycle after word 3 is stored.
REQ-033 core_dv_in = 0xDEADBEEF during WAIT_TX of byte 5 -> ovf_out pulses once and the remaining bytes are unchanged.
REQ-034 Spurious tx_done_in in IDLE, and tx_done_in held off for 200 cycles in WAIT_TX -> no state change, tx_byte_out stable.
REQ-035 rst_n pulsed low in WAIT_TX of byte 7 -> all outputs 0 immediately; a subsequent new block streams correctly from byte 0.

Source files
------------

// File: rtl/mp_out.sv
// mp_out: gathers four ciphertext words from the AES core into one block and
// streams it to a UART transmitter one byte at a time, MSB first.
module mp_out #(
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_BYTES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] core_data_in,
  input  logic                  core_dv_in,
  input  logic                  tx_done_in,
  output logic [7:0]            tx_byte_out,
  output logic                  tx_dv_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  ovf_out
);

  localparam int BLOCK_BITS = BLOCK_BYTES * 8;
  localparam int WORDS      = BLOCK_BITS / DATA_WIDTH;
  localparam int WCW        = $clog2(WORDS + 1);
  localparam int BCW        = $clog2(BLOCK_BYTES);
  localparam int BIW        = $clog2(BLOCK_BITS);

  localparam logic [WCW-1:0] LAST_WORD = WCW'(WORDS - 1);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BLOCK_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    SEND    = 3'd2,
    WAIT_TX = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [WCW-1:0]        word_cnt;
  logic [BCW-1:0]        byte_cnt;
  logic [BLOCK_BITS-1:0] block;
  logic [BIW-1:0]        byte_lsb;
  logic                  streaming;

  // Next-state decode; unused encodings fall back to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (core_dv_in) state_next = COLLECT;
      COLLECT: if (core_dv_in && (word_cnt == LAST_WORD)) state_next = SEND;
      SEND:    state_next = WAIT_TX;
      WAIT_TX: if (tx_done_in) state_next = (byte_cnt == LAST_BYTE) ? DONE : SEND;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, counters and block register.
  // Words shift in from the bottom, so after the last word the first one
  // sits in the top slice -- same layout as indexed storage by arrival order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      word_cnt <= '0;
      byte_cnt <= '0;
      block    <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (core_dv_in) begin
            block    <= {block[BLOCK_BITS-DATA_WIDTH-1:0], core_data_in};
            word_cnt <= WCW'(1);
          end
        end
        COLLECT: begin
          if (core_dv_in) begin
            block    <= {block[BLOCK_BITS-DATA_WIDTH-1:0], core_data_in};
            word_cnt <= word_cnt + 1'b1;
            if (word_cnt == LAST_WORD) byte_cnt <= '0;
          end
        end
        SEND: ;
        WAIT_TX: begin
          if (tx_done_in && (byte_cnt != LAST_BYTE)) byte_cnt <= byte_cnt + 1'b1;
        end
        DONE: begin
          word_cnt <= '0;
          byte_cnt <= '0;
        end
        default: begin
          word_cnt <= '0;
          byte_cnt <= '0;
        end
      endcase
    end
  end

  // Outputs decoded from the registered state; ovf_out follows core_dv_in directly.
  always_comb begin
    streaming   = (state == SEND) || (state == WAIT_TX);
    byte_lsb    = BIW'(BLOCK_BITS - 8) - BIW'({byte_cnt, 3'b000});
    tx_byte_out = streaming ? block[byte_lsb +: 8] : '0;
    tx_dv_out   = (state == SEND);
    busy_out    = (state != IDLE);
    done_out    = (state == DONE);
    ovf_out     = core_dv_in && (streaming || (state == DONE));
  end

endmodule
